// File: rtl/esl_safe_seq_pkg.sv
// Shared types for the ESL safety start-up / trip-recovery sequencer.
package esl_safe_seq_pkg;

    localparam int unsigned TRIP_CNT_W = 4;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_RESET_DOC = 3'd1,
        S_ARMING    = 3'd2,
        S_RUN       = 3'd3,
        S_TRIPPED   = 3'd4,
        S_HOLDOFF   = 3'd5,
        S_LOCKOUT   = 3'd6
    } seq_state_t;

    function automatic longint unsigned max2(input longint unsigned a, input longint unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/esl_comp_pair_sync.sv
// Synchronizes the DOC powerdown pair and flags a trip or a stuck/equal pair.
module esl_comp_pair_sync
    import esl_safe_seq_pkg::*;
#(
    parameter int unsigned P_DISAGREE_CYCLES = 8
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_pd_p,
    input  logic i_pd_n,
    output logic tripped,
    output logic disagree
);

    localparam int unsigned CW = $clog2(P_DISAGREE_CYCLES + 1);

    logic          r_p1, r_p2, r_n1, r_n2;
    logic [CW-1:0] r_cnt;

    // Flops reset to the "safe" pair so reset exit never looks like a disagreement.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_p1  <= 1'b0;
            r_p2  <= 1'b0;
            r_n1  <= 1'b1;
            r_n2  <= 1'b1;
            r_cnt <= '0;
        end else begin
            r_p1 <= i_pd_p;
            r_p2 <= r_p1;
            r_n1 <= i_pd_n;
            r_n2 <= r_n1;
            if (r_p2 == r_n2) begin
                if (r_cnt != CW'(P_DISAGREE_CYCLES))
                    r_cnt <= r_cnt + CW'(1);
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign tripped  = r_p2 & ~r_n2;
    assign disagree = (r_cnt == CW'(P_DISAGREE_CYCLES));

endmodule

// File: rtl/esl_safe_seq.sv
// Safety DOC start-up / trip-recovery sequencer with complementary motor enable.
// Optional feature: ESL_SAFE_SEQ_LOCKOUT_EN enables restart limit and pair-fault lockout.
module esl_safe_seq
    import esl_safe_seq_pkg::*;
#(
    parameter int unsigned P_RESET_HOLD_CYCLES = 64,
    parameter int unsigned P_ARM_CYCLES        = 100_000,
    parameter int unsigned P_HOLDOFF_CYCLES    = 2_000_000,
    parameter int unsigned P_DISAGREE_CYCLES   = 8,
    parameter int unsigned P_MAX_RESTARTS      = 3,
    parameter int unsigned P_CNT_WIDTH         = 24
) (
    input  logic                  esl_clk,
    input  logic                  esl_reset,
    input  logic                  start_req,
    output logic                  start_ack,
    input  logic                  clear_req,
    input  logic                  pd_p,
    input  logic                  pd_n,
    output logic                  reset_safety_n,
    output logic                  motor_enable_p,
    output logic                  motor_enable_n,
    output logic [2:0]            seq_state,
    output logic [TRIP_CNT_W-1:0] trip_count,
    output logic                  seq_fault
);

    localparam longint unsigned L_MAX_CYC =
        max2(max2(P_RESET_HOLD_CYCLES, P_ARM_CYCLES), max2(P_HOLDOFF_CYCLES, P_DISAGREE_CYCLES));

    generate
        if ((L_MAX_CYC >> P_CNT_WIDTH) != 0) begin : g_cnt_too_narrow
            $error("esl_safe_seq: P_CNT_WIDTH too narrow for the largest cycle parameter");
        end
        if (P_MAX_RESTARTS < 1 || P_MAX_RESTARTS > 15) begin : g_bad_restarts
            $error("esl_safe_seq: P_MAX_RESTARTS must be within the trip counter range 1..15");
        end
    endgenerate

    localparam logic [P_CNT_WIDTH-1:0] L_LD_HOLD    = P_CNT_WIDTH'(P_RESET_HOLD_CYCLES - 1);
    localparam logic [P_CNT_WIDTH-1:0] L_LD_ARM     = P_CNT_WIDTH'(P_ARM_CYCLES - 1);
    localparam logic [P_CNT_WIDTH-1:0] L_LD_HOLDOFF = P_CNT_WIDTH'(P_HOLDOFF_CYCLES - 1);

    seq_state_t                r_state, w_nxt;
    logic [P_CNT_WIDTH-1:0]    r_cnt, w_cnt_nxt;
    logic [TRIP_CNT_W-1:0]     r_trip_cnt;
    logic                      r_fault, r_rsn, r_mep, r_men, r_ack;
    logic                      w_tripped, w_disagree;

    esl_comp_pair_sync #(
        .P_DISAGREE_CYCLES(P_DISAGREE_CYCLES)
    ) u_pair_sync (
        .i_clk   (esl_clk),
        .i_rst_n (esl_reset),
        .i_pd_p  (pd_p),
        .i_pd_n  (pd_n),
        .tripped (w_tripped),
        .disagree(w_disagree)
    );

    always_comb begin
        w_nxt     = r_state;
        w_cnt_nxt = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (start_req) begin
                    w_nxt     = S_RESET_DOC;
                    w_cnt_nxt = L_LD_HOLD;
                end
            end
            S_RESET_DOC: begin
                if (!start_req) begin
                    w_nxt = S_IDLE;
                end else if (r_cnt == '0) begin
                    w_nxt     = S_ARMING;
                    w_cnt_nxt = L_LD_ARM;
                end else begin
                    w_cnt_nxt = r_cnt - P_CNT_WIDTH'(1);
                end
            end
            S_ARMING: begin
                if (w_tripped)           w_nxt = S_TRIPPED;
                else if (!start_req)     w_nxt = S_IDLE;
                else if (r_cnt == '0)    w_nxt = S_RUN;
                else                     w_cnt_nxt = r_cnt - P_CNT_WIDTH'(1);
            end
            S_RUN: begin
                if (w_tripped)           w_nxt = S_TRIPPED;
                else if (!start_req)     w_nxt = S_IDLE;
            end
            S_TRIPPED: begin
                if (clear_req) begin
`ifdef ESL_SAFE_SEQ_LOCKOUT_EN
                    if (32'(r_trip_cnt) >= P_MAX_RESTARTS) begin
                        w_nxt = S_LOCKOUT;
                    end else begin
                        w_nxt     = S_HOLDOFF;
                        w_cnt_nxt = L_LD_HOLDOFF;
                    end
`else
                    w_nxt     = S_HOLDOFF;
                    w_cnt_nxt = L_LD_HOLDOFF;
`endif
                end
            end
            S_HOLDOFF: begin
                if (r_cnt == '0) begin
                    if (start_req) begin
                        w_nxt     = S_RESET_DOC;
                        w_cnt_nxt = L_LD_HOLD;
                    end else begin
                        w_nxt = S_IDLE;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - P_CNT_WIDTH'(1);
                end
            end
            S_LOCKOUT: w_nxt = S_LOCKOUT;
            default:   w_nxt = S_LOCKOUT;
        endcase
        // A persistent pair fault overrides every other transition.
`ifdef ESL_SAFE_SEQ_LOCKOUT_EN
        if (w_disagree)
            w_nxt = S_LOCKOUT;
`else
        if (w_disagree && w_nxt != S_LOCKOUT)
            w_nxt = S_TRIPPED;
`endif
    end

    // Outputs are decoded from the next state so they move with seq_state.
    always_ff @(posedge esl_clk or negedge esl_reset) begin
        if (!esl_reset) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_trip_cnt <= '0;
            r_fault    <= 1'b0;
            r_rsn      <= 1'b0;
            r_mep      <= 1'b0;
            r_men      <= 1'b1;
            r_ack      <= 1'b0;
        end else begin
            r_state <= w_nxt;
            r_cnt   <= w_cnt_nxt;
            r_rsn   <= (w_nxt == S_ARMING) || (w_nxt == S_RUN) || (w_nxt == S_TRIPPED);
            r_mep   <= (w_nxt == S_RUN);
            r_men   <= (w_nxt != S_RUN);
            r_ack   <= (w_nxt == S_RUN);
            if (w_nxt == S_TRIPPED && r_state != S_TRIPPED && r_trip_cnt != '1)
                r_trip_cnt <= r_trip_cnt + TRIP_CNT_W'(1);
            if (w_disagree)
                r_fault <= 1'b1;
        end
    end

    assign seq_state      = r_state;
    assign trip_count     = r_trip_cnt;
    assign seq_fault      = r_fault;
    assign reset_safety_n = r_rsn;
    assign motor_enable_p = r_mep;
    assign motor_enable_n = r_men;
    assign start_ack      = r_ack;

endmodule

// File: doc/esl_safe_seq.md
# esl_safe_seq

Start-up and trip-recovery sequencer for the safety DOC channel, running in the ESL clock domain beside the DOC. It owns the DOC safety reset (`reset_safety_n`), holds it through an arming window, and grants a complementary motor-enable pair only while the DOC powerdown pair reads "safe". After a trip it requires an operator clear and a hold-off before restarting. It can also lock out permanently after repeated trips.

## Interface
Parameters:
- P_RESET_HOLD_CYCLES, 64: cycles `reset_safety_n` is held low in RESET_DOC.
- P_ARM_CYCLES, 100_000: arming window in cycles (5 ms at 20 MHz).
- P_HOLDOFF_CYCLES, 2_000_000: post-clear hold-off in cycles (100 ms at 20 MHz).
- P_DISAGREE_CYCLES, 8: consecutive cycles with pd_p==pd_n that count as a pair fault.
- P_MAX_RESTARTS, 3: trip count at which a clear leads to LOCKOUT.
- P_CNT_WIDTH, 24: width of the shared down-counter. Must hold the largest cycle parameter; elaboration error otherwise.

Ports:
- esl_clk, in, 1: ESL reference clock.
- esl_reset, in, 1: asynchronous active-low reset.
- start_req, in, 1: synchronous level request to run.
- start_ack, out, 1: high only in RUN.
- clear_req, in, 1: synchronous single-cycle trip clear.
- pd_p, in, 1: DOC motor_powerdown_p (asynchronous).
- pd_n, in, 1: DOC motor_powerdown_n (asynchronous).
- reset_safety_n, out, 1: safety reset to DOC.
- motor_enable_p, out, 1: complementary enable, true half.
- motor_enable_n, out, 1: complementary enable, inverted half.
- seq_state, out, 3: current state encoding.
- trip_count, out, 4: saturating trip counter.
- seq_fault, out, 1: latched pd pair disagreement.

## Operation
- pd_p and pd_n each pass through a 2-flop synchronizer.
- tripped = sync pd_p==1 and sync pd_n==0.
- A disagreement counter increments while sync pd_p==sync pd_n and clears otherwise. Reaching P_DISAGREE_CYCLES sets seq_fault and forces LOCKOUT from any state. seq_fault clears only on esl_reset.
- State encodings: IDLE=0, RESET_DOC=1, ARMING=2, RUN=3, TRIPPED=4, HOLDOFF=5, LOCKOUT=6. Code 7 is illegal and is treated as LOCKOUT.
- IDLE: reset_safety_n=0, enable off. start_req=1 → RESET_DOC; counter loads P_RESET_HOLD_CYCLES-1.
- RESET_DOC: reset_safety_n=0. Counter reaches 0 → ARMING; counter loads P_ARM_CYCLES-1.
- ARMING: reset_safety_n=1.
  - tripped → TRIPPED.
  - Counter reaches 0 → RUN.
- RUN: enable on (motor_enable_p=1, motor_enable_n=0).
  - tripped → TRIPPED.
  - start_req=0 → IDLE.
  - Trip has priority over start_req=0.
- TRIPPED: enable off, reset_safety_n=1 (the DOC stays latched).
  - trip_count increments on entry, saturating at 15.
  - clear_req with trip_count ≥ P_MAX_RESTARTS → LOCKOUT.
  - Otherwise clear_req → HOLDOFF; counter loads P_HOLDOFF_CYCLES-1.
  - start_req is ignored.
- HOLDOFF: reset_safety_n=0, enable off. Counter reaches 0: start_req=1 → RESET_DOC, else IDLE.
- LOCKOUT: reset_safety_n=0, enable off. Exit only on esl_reset.
- start_req=0 in RESET_DOC or ARMING → IDLE next cycle.
- clear_req outside TRIPPED has no effect.

## Timing
- Reset values: state IDLE, reset_safety_n=0, motor_enable_p=0, motor_enable_n=1, start_ack=0, trip_count=0, seq_fault=0, counter=0.
- All outputs are registered and decoded from the next state, so they change on the same edge as seq_state.
- pd_p rising edge → motor_enable_p low at most 3 esl_clk edges later (2 sync + 1 state).
- start_req rising in IDLE → reset_safety_n released P_RESET_HOLD_CYCLES+1 cycles later → RUN P_ARM_CYCLES cycles after that.
- Counter is unsigned and decrements only in timed states. A load value of 0 means one cycle in that state.
- Mid-operation reset: asynchronous return to the reset values. This guarantees enable off immediately.

## Configuration
- ESL_SAFE_SEQ_LOCKOUT_EN defined:
  - P_MAX_RESTARTS enforced.
  - Disagreement → LOCKOUT.
- ESL_SAFE_SEQ_LOCKOUT_EN undefined:
  - LOCKOUT unreachable; a clear always goes to HOLDOFF.
  - Disagreement → TRIPPED, with seq_fault still latched.
  - trip_count still counts (saturating at 15).

## Structure
- Package esl_safe_seq_pkg holds:
  - the state enum typedef (3-bit, encodings above);
  - the localparam for the trip counter width (4).
- Sub-module esl_comp_pair_sync holds the two 2-flop synchronizers plus the disagreement counter. It outputs `tripped` and `disagree`.

## Test plan
Test parameters: RESET_HOLD=4, ARM=8, HOLDOFF=16, MAX_RESTARTS=2, DISAGREE=8.
- Nominal start: start_req=1, pd_p=0/pd_n=1 → reset_safety_n low for 4 cycles, ARMING for 8 cycles, then start_ack=1, motor_enable_p=1/n=0.
- Trip in RUN: pd_p=1/pd_n=0 → motor_enable_p=0 within 3 cycles, seq_state=4, trip_count=1.
- Clear/restart: clear_req pulse with start_req=1 → HOLDOFF 16 cycles, then RESET_DOC; start_req=0 at HOLDOFF end → IDLE.
- Lockout (macro on): second trip then clear_req → seq_state=6, reset_safety_n=0. Start and clear are ignored until esl_reset.
- Pair fault: pd_p=pd_n=1 for 8 cycles during RUN → seq_fault=1. Expected state is 6 with the macro and 4 without it.
- Async reset while in RUN → all outputs take their reset values with no clock edge.
